// File: rtl/dev_alu_seq_pkg.sv
// Shared types for the sequential ALU: register width, operation codes
// and the controller state encoding.

package pkg_reg;
  // Default datapath width for register-file-sized operands.
  localparam int REG_WIDTH = 32;
endpackage

package pkg_alu;
  // ALU_NOP/ADD/SUB keep their original codes; newer ops are appended.
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7,
    ALU_MULU = 4'd8,
    ALU_DIVU = 4'd9
  } alu_op_t;

  // Controller states: IDLE accepts requests, MUL/DIV iterate one bit per cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } alu_state_t;

  // True for operations that run on the shared iterative datapath.
  function automatic logic is_iter_op(alu_op_t op);
    return (op == ALU_MULU) || (op == ALU_DIVU);
  endfunction
endpackage

// File: rtl/dev_alu_seq_iter.sv
// Shared iterative datapath for unsigned multiply (shift-add) and
// unsigned restoring divide. One result bit is produced per step.
// res_hi/res_lo present the register values the current step would
// write, so the controller can capture the final result on the last step
// without an extra cycle.

module dev_alu_seq_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             last,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  // part: product high half / partial remainder
  // shreg: multiplier bits (shifted out) / dividend bits becoming quotient
  // opnd: multiplicand / divisor
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shifted;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] part_nxt;
  logic [WIDTH-1:0] shreg_nxt;

  assign last     = (cnt == CW'(WIDTH - 1));
  assign div_zero = (opnd == '0);
  assign res_hi   = part_nxt;
  assign res_lo   = shreg_nxt;

  // One multiply or divide step computed from the current registers.
  always_comb begin
    mul_sum     = {1'b0, part} + ({(WIDTH+1){shreg[0]}} & {1'b0, opnd});
    div_shifted = {part, shreg[WIDTH-1]};
    div_diff    = div_shifted - {1'b0, opnd};
    part_nxt    = part;
    shreg_nxt   = shreg;
    if (is_div) begin
      // A clear top bit means the trial subtraction did not borrow.
      if (!div_diff[WIDTH]) begin
        part_nxt  = div_diff[WIDTH-1:0];
        shreg_nxt = {shreg[WIDTH-2:0], 1'b1};
      end else begin
        part_nxt  = div_shifted[WIDTH-1:0];
        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
      end
    end else begin
      part_nxt  = mul_sum[WIDTH:1];
      shreg_nxt = {mul_sum[0], shreg[WIDTH-1:1]};
    end
  end

  // Datapath registers: load captures operands, step advances one bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      part  <= '0;
      shreg <= '0;
      opnd  <= '0;
      cnt   <= '0;
    end else if (load) begin
      part  <= '0;
      shreg <= b;
      opnd  <= a;
      cnt   <= '0;
    end else if (step) begin
      part  <= part_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dev_alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift plus iterative
// unsigned multiply and divide. Every result is b OP a.
//
// Request handshake: start is a request qualified by busy. When busy=0,
// a start with a non-NOP op is taken at the rising edge; when busy=1,
// start is ignored. done pulses for one cycle when s/s_hi/flags update,
// and a new start may be taken in that same cycle.

module dev_alu_seq
  import pkg_alu::*;
#(
  parameter int WIDTH = pkg_reg::REG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_hi,
  output logic             stat_reg_cf,
  output logic             stat_reg_of,
  output logic             stat_reg_zf,
  output logic             stat_reg_sf
);

  localparam int SW = $clog2(WIDTH);

  alu_state_t state;
  alu_state_t state_nxt;

  logic load;
  logic step;
  logic wr_single;
  logic wr_iter;

  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;
  logic             it_last;
  logic             it_div_zero;

  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [SW-1:0]    amt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cf;
  logic             sc_of;

  assign busy = (state != IDLE);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath control.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    wr_single = 1'b0;
    wr_iter   = 1'b0;
    case (state)
      IDLE: begin
        if (start && (op != ALU_NOP)) begin
          if (is_iter_op(op)) begin
            load      = 1'b1;
            state_nxt = (op == ALU_MULU) ? MUL : DIV;
          end else begin
            wr_single = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        step = 1'b1;
        if (it_last) begin
          wr_iter   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  dev_alu_seq_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .is_div  (state == DIV),
    .a       (a),
    .b       (b),
    .res_hi  (it_hi),
    .res_lo  (it_lo),
    .last    (it_last),
    .div_zero(it_div_zero)
  );

  // Single-cycle results and carry/overflow for the current op.
  // Shifts use a one-bit extension so the last bit shifted out lands in
  // a fixed position (zero when the amount is zero).
  always_comb begin
    add_ext = {1'b0, b} + {1'b0, a};
    sub_ext = {1'b0, b} - {1'b0, a};
    amt     = a[SW-1:0];
    shl_ext = {1'b0, b} << amt;
    shr_ext = {b, 1'b0} >> amt;
    sc_res  = '0;
    sc_cf   = 1'b0;
    sc_of   = 1'b0;
    case (op)
      ALU_ADD: begin
        sc_res = add_ext[WIDTH-1:0];
        sc_cf  = add_ext[WIDTH];
        sc_of  = (b[WIDTH-1] == a[WIDTH-1]) && (add_ext[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res = sub_ext[WIDTH-1:0];
        sc_cf  = sub_ext[WIDTH];
        sc_of  = (b[WIDTH-1] != a[WIDTH-1]) && (sub_ext[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_AND: sc_res = b & a;
      ALU_OR:  sc_res = b | a;
      ALU_XOR: sc_res = b ^ a;
      ALU_SHL: begin
        sc_res = shl_ext[WIDTH-1:0];
        sc_cf  = shl_ext[WIDTH];
      end
      ALU_SHR: begin
        sc_res = shr_ext[WIDTH:1];
        sc_cf  = shr_ext[0];
      end
      default: begin
        sc_res = '0;
        sc_cf  = 1'b0;
        sc_of  = 1'b0;
      end
    endcase
  end

  // Result and flag registers; they change only on a done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      s           <= '0;
      s_hi        <= '0;
      stat_reg_cf <= 1'b0;
      stat_reg_of <= 1'b0;
      stat_reg_zf <= 1'b0;
      stat_reg_sf <= 1'b0;
    end else begin
      done <= wr_single | wr_iter;
      if (wr_single) begin
        s           <= sc_res;
        s_hi        <= '0;
        stat_reg_cf <= sc_cf;
        stat_reg_of <= sc_of;
        stat_reg_zf <= (sc_res == '0);
        stat_reg_sf <= sc_res[WIDTH-1];
      end else if (wr_iter) begin
        s           <= it_lo;
        s_hi        <= it_hi;
        if (state == MUL) begin
          stat_reg_cf <= (it_hi != '0);
          stat_reg_of <= (it_hi != '0);
        end else begin
          stat_reg_cf <= 1'b0;
          stat_reg_of <= it_div_zero;
        end
        stat_reg_zf <= (it_lo == '0);
        stat_reg_sf <= it_lo[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_dev_alu_seq.sv
// Bench for dev_alu_seq at WIDTH=8. Scenario tasks drive requests and
// check timing inline; a reference model pushes expected results to a
// queue that a monitor pops on every done pulse.

module tb_dev_alu_seq;
  import pkg_alu::*;

  localparam int W  = 8;
  localparam int EW = 2 * W + 4;

  logic          clk = 1'b0;
  logic          rst;
  alu_op_t       op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          start;
  logic          busy;
  logic          done;
  logic [W-1:0]  s;
  logic [W-1:0]  s_hi;
  logic          cf;
  logic          of;
  logic          zf;
  logic          sf;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected {s, s_hi, cf, of, zf, sf} per done pulse.
  logic [EW-1:0] exp_q[$];

  // Clock and reset
  always #5 clk = ~clk;

  dev_alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .a          (a),
    .b          (b),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .s          (s),
    .s_hi       (s_hi),
    .stat_reg_cf(cf),
    .stat_reg_of(of),
    .stat_reg_zf(zf),
    .stat_reg_sf(sf)
  );

  // Reference model, result = y OP x (x is port a, y is port b).
  function automatic logic [EW-1:0] model(alu_op_t o, logic [W-1:0] x, logic [W-1:0] y);
    logic [W-1:0] r;
    logic [W-1:0] rh;
    logic c;
    logic v;
    int ua, ub, sa, sb, t, amt;
    r = '0; rh = '0; c = 1'b0; v = 1'b0;
    ua = int'(x); ub = int'(y);
    sa = int'($signed(x)); sb = int'($signed(y));
    amt = ua % W;
    case (o)
      ALU_ADD: begin
        t = ub + ua; r = W'(t); c = (t > (1 << W) - 1);
        t = sb + sa; v = (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
      end
      ALU_SUB: begin
        t = ub - ua; r = W'(t); c = (ub < ua);
        t = sb - sa; v = (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
      end
      ALU_AND: r = y & x;
      ALU_OR:  r = y | x;
      ALU_XOR: r = y ^ x;
      ALU_SHL: begin r = y << amt; c = (amt == 0) ? 1'b0 : y[W-amt]; end
      ALU_SHR: begin r = y >> amt; c = (amt == 0) ? 1'b0 : y[amt-1]; end
      ALU_MULU: begin
        t = ub * ua; r = W'(t); rh = W'(t >> W); c = (rh != '0); v = c;
      end
      ALU_DIVU: begin
        if (ua == 0) begin r = '1; rh = y; v = 1'b1; end
        else begin r = W'(ub / ua); rh = W'(ub % ua); end
      end
      default: ;
    endcase
    return {r, rh, c, v, (r == '0), r[W-1]};
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] got_v;
    if (rst === 1'b0 && done === 1'b1) begin
      tests_run++;
      got_v = {s, s_hi, cf, of, zf, sf};
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_done: got done=1 result=%h, required no done pulse", got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          tests_failed++;
          $display("FAIL scoreboard_result: got {s,s_hi,cf,of,zf,sf}=%h, required %h", got_v, exp_v);
        end
      end
    end
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the cycle after acceptance.
  task automatic issue(alu_op_t o, logic [W-1:0] x, logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    next_cycle();
    start = 1'b0;
    op = alu_op_t'(4'($urandom_range(0, 9)));
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
  endtask

  // Wait (bounded) until done is high; counts as one comparison.
  task automatic wait_done(string name, int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      next_cycle();
      n++;
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_timeout: got no done within %0d cycles, required done", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = ALU_NOP; a = '0; b = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got busy=%b done=%b, required 0 0", busy, done);
    end
    tests_run++;
    if (s !== '0 || s_hi !== '0) begin
      tests_failed++;
      $display("FAIL reset_result: got s=%h s_hi=%h, required 00 00", s, s_hi);
    end
    tests_run++;
    if ({cf, of, zf, sf} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got cf,of,zf,sf=%b, required 0000", {cf, of, zf, sf});
    end
  endtask

  task automatic test_single();
    exp_q.push_back(model(ALU_ADD, 8'h01, 8'h7F));
    issue(ALU_ADD, 8'h01, 8'h7F);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || s !== 8'h80 || {cf, of, sf, zf} !== 4'b0110) begin
      tests_failed++;
      $display("FAIL add_overflow: got done=%b busy=%b s=%h cf,of,sf,zf=%b, required 1 0 80 0110",
               done, busy, s, {cf, of, sf, zf});
    end
    exp_q.push_back(model(ALU_SUB, 8'h01, 8'h00));
    issue(ALU_SUB, 8'h01, 8'h00);
    tests_run++;
    if (done !== 1'b1 || s !== 8'hFF || cf !== 1'b1 || of !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_borrow: got done=%b s=%h cf=%b of=%b, required 1 ff 1 0", done, s, cf, of);
    end
    exp_q.push_back(model(ALU_SHL, 8'h09, 8'h81));
    issue(ALU_SHL, 8'h09, 8'h81);
    tests_run++;
    if (done !== 1'b1 || s !== 8'h02 || cf !== 1'b1 || of !== 1'b0) begin
      tests_failed++;
      $display("FAIL shl_masked_amount: got done=%b s=%h cf=%b of=%b, required 1 02 1 0", done, s, cf, of);
    end
    // Random single-cycle ops issued back to back.
    for (int i = 0; i < 24; i++) begin
      alu_op_t o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      o = alu_op_t'(4'($urandom_range(1, 7)));
      x = (i < 4) ? W'(i * 8) : W'($urandom_range(0, 255));
      y = W'($urandom_range(0, 255));
      exp_q.push_back(model(o, x, y));
      issue(o, x, y);
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_timing: got done=%b busy=%b for op %0d, required 1 0", done, busy, o);
      end
    end
  endtask

  task automatic test_nop();
    logic [W-1:0] s_prev;
    next_cycle();
    s_prev = s;
    issue(ALU_NOP, 8'h12, 8'h34);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || s !== s_prev) begin
      tests_failed++;
      $display("FAIL nop_no_effect: got done=%b busy=%b s=%h, required 0 0 %h", done, busy, s, s_prev);
    end
    // Operand changes without start leave the result registers alone.
    for (int i = 0; i < 3; i++) next_cycle();
    tests_run++;
    if (s !== s_prev) begin
      tests_failed++;
      $display("FAIL hold_result: got s=%h, required %h", s, s_prev);
    end
  endtask

  task automatic test_mulu();
    exp_q.push_back(model(ALU_MULU, 8'hFF, 8'hFF));
    issue(ALU_MULU, 8'hFF, 8'hFF);
    for (int k = 1; k <= W; k++) begin
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL mulu_busy_c%0d: got busy=%b done=%b, required 1 0", k, busy, done);
      end
      if (k == 4) begin
        op = ALU_ADD; a = 8'h01; b = 8'h01; start = 1'b1;
      end
      next_cycle();
      start = 1'b0;
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || s !== 8'h01 || s_hi !== 8'hFE || cf !== 1'b1 || of !== 1'b1) begin
      tests_failed++;
      $display("FAIL mulu_result: got done=%b busy=%b s=%h s_hi=%h cf=%b of=%b, required 1 0 01 fe 1 1",
               done, busy, s, s_hi, cf, of);
    end
  endtask

  task automatic test_divu();
    exp_q.push_back(model(ALU_DIVU, 8'h07, 8'h64));
    issue(ALU_DIVU, 8'h07, 8'h64);
    wait_done("divu", W + 2);
    tests_run++;
    if (s !== 8'h0E || s_hi !== 8'h02) begin
      tests_failed++;
      $display("FAIL divu_result: got s=%h s_hi=%h, required 0e 02", s, s_hi);
    end
    exp_q.push_back(model(ALU_DIVU, 8'h00, 8'h2A));
    issue(ALU_DIVU, 8'h00, 8'h2A);
    wait_done("divu_zero", W + 2);
    tests_run++;
    if (s !== 8'hFF || s_hi !== 8'h2A || of !== 1'b1 || cf !== 1'b0) begin
      tests_failed++;
      $display("FAIL divu_by_zero: got s=%h s_hi=%h of=%b cf=%b, required ff 2a 1 0", s, s_hi, of, cf);
    end
  endtask

  task automatic test_reset_abort();
    issue(ALU_MULU, 8'h12, 8'h34);
    next_cycle();
    // Cycle 3: reset together with a start that must be ignored.
    rst = 1'b1; op = ALU_ADD; a = 8'h11; b = 8'h22; start = 1'b1;
    next_cycle();
    rst = 1'b0; start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== '0 || s_hi !== '0) begin
      tests_failed++;
      $display("FAIL reset_abort: got busy=%b done=%b s=%h s_hi=%h, required 0 0 00 00", busy, done, s, s_hi);
    end
    exp_q.push_back(model(ALU_ADD, 8'h05, 8'h03));
    issue(ALU_ADD, 8'h05, 8'h03);
    tests_run++;
    if (done !== 1'b1 || s !== 8'h08) begin
      tests_failed++;
      $display("FAIL add_after_abort: got done=%b s=%h, required 1 08", done, s);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(model(ALU_MULU, 8'hFF, 8'hFF));
    issue(ALU_MULU, 8'hFF, 8'hFF);
    for (int k = 1; k <= W; k++) next_cycle();
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_mulu_done: got done=%b in cycle 9, required 1", done);
    end
    exp_q.push_back(model(ALU_XOR, 8'h0F, 8'hFF));
    issue(ALU_XOR, 8'h0F, 8'hFF);
    tests_run++;
    if (done !== 1'b1 || s !== 8'hF0 || s_hi !== 8'h00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_xor: got done=%b s=%h s_hi=%h busy=%b, required 1 f0 00 0", done, s, s_hi, busy);
    end
  endtask

  task automatic test_random_iter();
    for (int i = 0; i < 12; i++) begin
      alu_op_t o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      o = ($urandom_range(0, 1) == 0) ? ALU_MULU : ALU_DIVU;
      x = (i % 5 == 4) ? 8'h00 : W'($urandom_range(0, 255));
      y = W'($urandom_range(0, 255));
      exp_q.push_back(model(o, x, y));
      issue(o, x, y);
      wait_done("random_iter", W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_nop();
    test_mulu();
    test_divu();
    test_reset_abort();
    test_back_to_back();
    test_random_iter();
    for (int i = 0; i < 4; i++) next_cycle();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
